// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared types and constants for the RAM arbiter:
//   - ramstate_t  : status reported by the RAM model each cycle
//   - arb_state_t : arbiter grant state
//   - ERR_WORD_DEFAULT : load value substituted on ERROR / timeout
//   - ram_done()  : true when the RAM has finished the current access
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hBAD1_BAD1;

  // RAM has finished the access, successfully or not.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
//   Bundles the cache-side request streams and the RAM-side bus.
//   Cache side : iREN/iaddr -> iwait/iload (fetch), dREN/dWEN/daddr/dstore ->
//                dwait/dload (data), err (sticky error status).
//   RAM side   : ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate.
//   Modports: slave = the arbiter, master = the surrounding cache + RAM.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares a single-ported RAM between instruction fetch and data accesses.
//   One requester is granted at a time; the grant is held until the RAM
//   reports ACCESS or ERROR, the timer reaches TIMEOUT, or the requester
//   drops its request (abort). Data wins by default, but after DSTREAK_MAX
//   consecutive data grants with a fetch waiting, the fetch is forced.
//   Ports:
//     CLK  - clock, rising edge
//     nRST - asynchronous reset, active high
//     bus  - memory_arbiter_if.slave (cache requests, RAM bus, err flag)
//   RAM strobes, waits and loads are combinational from the registered
//   state, the granted requester's inputs and ramstate.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_WORD    = ERR_WORD_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);

  localparam logic [3:0] STREAK_MAX_C = DSTREAK_MAX[3:0];
  localparam logic [7:0] TIMEOUT_C    = TIMEOUT[7:0];

  arb_state_t  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  timer_q, timer_d;
  logic        err_q, err_d;

  logic        d_req_s;
  logic        done_s;
  logic        fail_s;
  logic [31:0] result_s;
  logic        iwait_s, dwait_s, ramren_s, ramwen_s;
  logic [31:0] iload_s, dload_s, ramaddr_s, ramstore_s;

  assign d_req_s  = bus.dREN | bus.dWEN;
  // A grant ends on a RAM verdict or when the timer has run out.
  assign done_s   = ram_done(bus.ramstate) | (timer_q == TIMEOUT_C);
  assign fail_s   = (bus.ramstate != ACCESS);
  assign result_s = fail_s ? ERR_WORD : bus.ramload;

  // Next-state, counters and all combinational outputs.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    timer_d    = timer_q;
    err_d      = err_q;
    iwait_s    = bus.iREN;
    dwait_s    = d_req_s;
    iload_s    = 32'h0000_0000;
    dload_s    = 32'h0000_0000;
    ramren_s   = 1'b0;
    ramwen_s   = 1'b0;
    ramaddr_s  = 32'h0000_0000;
    ramstore_s = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        // With no fetch waiting, the starvation streak is meaningless.
        if (!bus.iREN) begin
          streak_d = 4'd0;
        end else begin
          streak_d = streak_q;
        end
        if (d_req_s && (!bus.iREN || (streak_q < STREAK_MAX_C))) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = IDLE;
        end
      end

      IGRANT: begin
        timer_d = timer_q + 8'd1;
        if (!bus.iREN) begin
          // Requester withdrew: abort quietly, strobes already off.
          state_d = IDLE;
        end else begin
          ramren_s  = 1'b1;
          ramaddr_s = bus.iaddr;
          if (done_s) begin
            iwait_s  = 1'b0;
            iload_s  = result_s;
            state_d  = IDLE;
            streak_d = 4'd0;
            err_d    = err_q | fail_s;
          end else begin
            state_d = IGRANT;
          end
        end
      end

      DGRANT: begin
        timer_d = timer_q + 8'd1;
        if (!d_req_s) begin
          state_d = IDLE;
        end else begin
          // dREN and dWEN together count as a write.
          ramren_s   = bus.dREN & ~bus.dWEN;
          ramwen_s   = bus.dWEN;
          ramaddr_s  = bus.daddr;
          ramstore_s = bus.dstore;
          if (done_s) begin
            dwait_s = 1'b0;
            dload_s = result_s;
            state_d = IDLE;
            err_d   = err_q | fail_s;
            if (bus.iREN && (streak_q < STREAK_MAX_C)) begin
              streak_d = streak_q + 4'd1;
            end else begin
              streak_d = streak_q;
            end
          end else begin
            state_d = DGRANT;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, streak, timer and sticky error registers.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      timer_q  <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign bus.iwait    = iwait_s;
  assign bus.iload    = iload_s;
  assign bus.dwait    = dwait_s;
  assign bus.dload    = dload_s;
  assign bus.ramREN   = ramren_s;
  assign bus.ramWEN   = ramwen_s;
  assign bus.ramaddr  = ramaddr_s;
  assign bus.ramstore = ramstore_s;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Scoreboard bench for memory_arbiter. Requesters push the expected
//   load of each request (derived from an address-keyed reference memory
//   and the fault region of the address) into per-stream queues; a monitor
//   pops and compares whenever a wait output falls. A behavioural RAM
//   answers with random latency; addresses 0xE... answer ERROR and 0xF...
//   never answer (timeout).
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int          DMAX        = 4;
  localparam int          TMO         = 8;
  localparam logic [31:0] ERRW        = 32'hBAD1_BAD1;
  localparam int          WAIT_BUDGET = 40;

  typedef struct packed {
    logic [31:0] load;
    logic        is_err;
  } exp_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;

  memory_arbiter_if bus();

  memory_arbiter #(.DSTREAK_MAX(DMAX), .TIMEOUT(TMO), .ERR_WORD(ERRW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial forever #5 CLK = ~CLK;

  int   checks   = 0;
  int   failures = 0;
  exp_t i_q[$];
  exp_t d_q[$];
  bit   exp_err  = 1'b0;
  int   d_while_i = 0;
  int   last_dwi  = -1;
  int   lat_mode  = -1;
  logic [31:0] last_wr_addr  = 32'h0;
  logic [31:0] last_wr_store = 32'h0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ram_mem [logic [31:0]];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check32(name, {31'd0, act}, {31'd0, req});
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_3C3C;
  endfunction

  // 0: normal, 1: RAM reports ERROR, 2: RAM never answers
  function automatic int kind(input logic [31:0] a);
    if (a[31:28] == 4'hE) return 1;
    else if (a[31:28] == 4'hF) return 2;
    else return 0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : rom(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : rom(a);
  endfunction

  function automatic exp_t exp_read(input logic [31:0] a);
    exp_t e;
    if (kind(a) != 0) begin e.load = ERRW; e.is_err = 1'b1; end
    else begin e.load = ref_rd(a); e.is_err = 1'b0; end
    return e;
  endfunction

  function automatic exp_t exp_write(input logic [31:0] a, input logic [31:0] st);
    exp_t e;
    if (kind(a) != 0) begin e.load = ERRW; e.is_err = 1'b1; end
    else begin e.load = 32'h0; e.is_err = 1'b0; ref_mem[a] = st; end
    return e;
  endfunction

  // Behavioural RAM: decides ramstate for the cycle at each falling edge.
  initial begin
    bit ram_active;
    int ram_cnt, ram_tgt;
    ram_active   = 1'b0;
    ram_cnt      = 0;
    ram_tgt      = 0;
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    forever begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        if (!ram_active) begin
          ram_active = 1'b1;
          ram_cnt    = 0;
          ram_tgt    = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
          if (kind(bus.ramaddr) == 2) ram_tgt = 1000000;
          check1("ram_one_strobe", bus.ramREN & bus.ramWEN, 1'b0);
          if (bus.ramWEN) begin
            check1("ram_wr_source", bus.dWEN && (bus.ramaddr == bus.daddr) &&
                   (bus.ramstore == bus.dstore), 1'b1);
            last_wr_addr  = bus.ramaddr;
            last_wr_store = bus.ramstore;
          end else begin
            check1("ram_rd_source", (bus.iREN && bus.ramaddr == bus.iaddr) ||
                   (bus.dREN && !bus.dWEN && bus.ramaddr == bus.daddr), 1'b1);
          end
        end
        if (ram_cnt >= ram_tgt) begin
          if (kind(bus.ramaddr) == 1) begin
            bus.ramstate = ERROR;
            bus.ramload  = $urandom();
          end else if (bus.ramWEN) begin
            ram_mem[bus.ramaddr] = bus.ramstore;
            bus.ramstate = ACCESS;
            bus.ramload  = 32'h0;
          end else begin
            bus.ramstate = ACCESS;
            bus.ramload  = ram_rd(bus.ramaddr);
          end
        end else begin
          bus.ramstate = BUSY;
          bus.ramload  = $urandom();
        end
        ram_cnt++;
      end else begin
        ram_active   = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = 32'h0;
      end
    end
  end

  // Monitor: compares completions against the scoreboard queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK); #2;
      if (!nRST) begin
        check1("err_flag", bus.err, exp_err);
        if (!bus.iREN) d_while_i = 0;
        if (bus.iREN && !bus.iwait) begin
          if (i_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL fetch_unexpected actual=completion required=none-pending");
          end else begin
            e = i_q.pop_front();
            check32("iload", bus.iload, e.load);
            check1("fetch_starve_bound", d_while_i <= DMAX, 1'b1);
            last_dwi  = d_while_i;
            d_while_i = 0;
            if (e.is_err) exp_err = 1'b1;
          end
        end else begin
          check32("iload_idle", bus.iload, 32'h0);
          check1("iwait_follow", bus.iwait, bus.iREN);
        end
        if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
          if (d_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL data_unexpected actual=completion required=none-pending");
          end else begin
            e = d_q.pop_front();
            check32("dload", bus.dload, e.load);
            if (bus.iREN) d_while_i++;
            if (e.is_err) exp_err = 1'b1;
          end
        end else begin
          check32("dload_idle", bus.dload, 32'h0);
          check1("dwait_follow", bus.dwait, bus.dREN | bus.dWEN);
        end
      end
    end
  end

  // Counts cycles with wait high; the completion cycle is not counted.
  task automatic wait_done(input bit is_i, output int waited);
    bit done_f;
    done_f = 1'b0;
    waited = 0;
    while (!done_f) begin
      @(negedge CLK); #2;
      if ((is_i ? bus.iwait : bus.dwait) == 1'b0) begin
        done_f = 1'b1;
      end else begin
        waited++;
        if (waited > WAIT_BUDGET) begin
          checks++; failures++;
          $display("FAIL %s_budget actual=still-waiting required=done-within-%0d",
                   is_i ? "fetch" : "data", WAIT_BUDGET);
          done_f = 1'b1;
        end
      end
    end
  endtask

  task automatic fetch_req(input logic [31:0] a, input bit hold, output int waited);
    @(posedge CLK); #1;
    bus.iREN  = 1'b1;
    bus.iaddr = a;
    i_q.push_back(exp_read(a));
    wait_done(1'b1, waited);
    if (!hold) begin
      @(posedge CLK); #1;
      bus.iREN = 1'b0;
    end
  endtask

  task automatic data_req(input bit ren, input bit wen, input logic [31:0] a,
                          input logic [31:0] st, input bit hold, output int waited);
    @(posedge CLK); #1;
    bus.dREN   = ren;
    bus.dWEN   = wen;
    bus.daddr  = a;
    bus.dstore = st;
    d_q.push_back(wen ? exp_write(a, st) : exp_read(a));
    wait_done(1'b0, waited);
    if (!hold) begin
      @(posedge CLK); #1;
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end
  endtask

  task automatic fetch_proc();
    int w, g, r;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      a = 32'hE000_0000 | 32'($urandom_range(0, 63) << 2);
      else if (r == 1) a = 32'hF000_0000;
      else             a = 32'($urandom_range(0, 255) << 2);
      g = int'($urandom_range(0, 3));
      fetch_req(a, (g == 0) && (n != 39), w);
      if (g > 1) repeat (g - 1) @(posedge CLK);
    end
  endtask

  task automatic data_proc();
    int w, g, r, op;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 19));
      op = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'hE000_0100;
      else if (r == 1) a = 32'hF000_0100;
      else             a = 32'h1000_0000 | 32'($urandom_range(0, 15) << 2);
      g = int'($urandom_range(0, 2));
      data_req(op < 6 || op == 9, op >= 6, a, $urandom(), (g == 0) && (n != 59), w);
      if (g > 1) repeat (g - 1) @(posedge CLK);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=no-finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wi, wd, w;
    bus.iREN = 1'b0; bus.iaddr = 32'h0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;

    // Reset state; waits follow the requests combinationally.
    repeat (2) @(posedge CLK); #1;
    bus.iREN = 1'b1; bus.dREN = 1'b1; #1;
    check1 ("rst_ramREN", bus.ramREN, 1'b0);
    check1 ("rst_ramWEN", bus.ramWEN, 1'b0);
    check32("rst_ramaddr", bus.ramaddr, 32'h0);
    check32("rst_iload", bus.iload, 32'h0);
    check32("rst_dload", bus.dload, 32'h0);
    check1 ("rst_err", bus.err, 1'b0);
    check1 ("rst_iwait", bus.iwait, 1'b1);
    check1 ("rst_dwait", bus.dwait, 1'b1);
    bus.iREN = 1'b0; bus.dREN = 1'b0; #1;
    check1 ("rst_iwait_low", bus.iwait, 1'b0);
    @(posedge CLK); #1;
    nRST = 1'b0;

    // Single fetch, two BUSY cycles before ACCESS.
    lat_mode = 2;
    ram_mem[32'h40] = 32'h8C01_0004;
    ref_mem[32'h40] = 32'h8C01_0004;
    fetch_req(32'h40, 1'b0, wi);
    check32("t1_iwait_cycles", 32'(wi), 32'd3);
    @(negedge CLK); #2;
    check1 ("t1_back_idle", bus.ramREN, 1'b0);

    // Simultaneous fetch and data write: data first, fetch two cycles later.
    lat_mode = 0;
    fork
      data_req(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, wd);
      fetch_req(32'h44, 1'b0, wi);
    join
    check32("t2_data_wait", 32'(wd), 32'd1);
    check32("t2_fetch_wait", 32'(wi), 32'd3);
    check32("t2_wr_addr", last_wr_addr, 32'h100);
    check32("t2_wr_store", last_wr_store, 32'hDEAD_BEEF);
    data_req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, wd);

    // Fetch held against continuous data reads: exactly DMAX data first.
    fork
      fetch_req(32'h80, 1'b0, wi);
      for (int k = 0; k < 6; k++)
        data_req(1'b1, 1'b0, 32'h1000_0000 + 32'(k * 4), 32'h0, k < 5, wd);
    join
    check32("t3_data_before_fetch", 32'(last_dwi), 32'(DMAX));
    check32("t3_fetch_wait", 32'(wi), 32'd9);
    fork
      fetch_req(32'h84, 1'b0, wi);
      data_req(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b0, wd);
    join
    check32("t3_data_wins_after", 32'(wd), 32'd1);

    // RAM stuck BUSY: abort on grant cycle TMO+1.
    data_req(1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b0, wd);
    check32("t4_timeout_wait", 32'(wd), 32'(TMO + 1));
    @(negedge CLK); #2;
    check1 ("t4_err_set", bus.err, 1'b1);
    fetch_req(32'h88, 1'b0, wi);
    check1 ("t4_err_sticky", bus.err, 1'b1);

    // Reset in the middle of a data write grant.
    lat_mode = 20;
    @(posedge CLK); #1;
    bus.dWEN = 1'b1; bus.daddr = 32'h1000_0040; bus.dstore = 32'h1234_5678;
    repeat (3) @(negedge CLK);
    #3;
    check1 ("t6_pre_ramWEN", bus.ramWEN, 1'b1);
    nRST = 1'b1; #1;
    check1 ("t6_ramWEN_drop", bus.ramWEN, 1'b0);
    check32("t6_ramaddr_drop", bus.ramaddr, 32'h0);
    check1 ("t6_err_clear", bus.err, 1'b0);
    i_q.delete(); d_q.delete(); exp_err = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
    lat_mode = 0;
    d_q.push_back(exp_write(32'h1000_0040, 32'h1234_5678));
    wait_done(1'b0, wd);
    check32("t6_regrant_wait", 32'(wd), 32'd1);
    check32("t6_regrant_store", last_wr_store, 32'h1234_5678);
    @(posedge CLK); #1;
    bus.dWEN = 1'b0;

    // ERROR during a fetch, then a normal fetch.
    lat_mode = 1;
    fetch_req(32'hE000_0010, 1'b0, wi);
    @(negedge CLK); #2;
    check1 ("t5_err_set", bus.err, 1'b1);
    fetch_req(32'h48, 1'b0, wi);
    check32("t5_next_wait", 32'(wi), 32'd2);

    // Random concurrent traffic.
    lat_mode = -1;
    fork
      fetch_proc();
      data_proc();
    join
    repeat (4) @(posedge CLK);
    check32("end_i_q_empty", 32'(i_q.size()), 32'd0);
    check32("end_d_q_empty", 32'(d_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
